// File: rtl/fpu_issue_ctl_if.sv
// Decode, FPU-issue and writeback signals of fpu_issue_ctl; master = decode/FPU side, slave = the controller.
// FPU_ISSUE_PERF_EN adds the two stall performance counters.
interface fpu_issue_ctl_if;
    logic [1:0]  in_valid;
    logic [12:0] in_op0;
    logic [12:0] in_op1;
    logic        in_ready;
    logic        flush;
    logic [2:0]  frm;
    logic        fpu_valid;
    logic        fpu_ready;
    logic [3:0]  fpu_op;
    logic        fpu_op_mod;
    logic [2:0]  fpu_rnd;
    logic [4:0]  fpu_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] rd_busy;
    logic        q_empty;
    logic        rnd_err;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_stall_full;
    logic [31:0] perf_stall_outst;
`endif

    modport master (
        output in_valid, in_op0, in_op1, flush, frm, fpu_ready, wb_valid, wb_rd,
`ifdef FPU_ISSUE_PERF_EN
        input  perf_stall_full, perf_stall_outst,
`endif
        input  in_ready, fpu_valid, fpu_op, fpu_op_mod, fpu_rnd, fpu_rd, rd_busy, q_empty, rnd_err
    );

    modport slave (
        input  in_valid, in_op0, in_op1, flush, frm, fpu_ready, wb_valid, wb_rd,
`ifdef FPU_ISSUE_PERF_EN
        output perf_stall_full, perf_stall_outst,
`endif
        output in_ready, fpu_valid, fpu_op, fpu_op_mod, fpu_rnd, fpu_rd, rd_busy, q_empty, rnd_err
    );
endinterface

// File: rtl/fpu_issue_ctl.sv
// In-order dual-enqueue / single-issue FPU sequencer with destination scoreboard and flush.
// Optional stall counters are enabled with `define FPU_ISSUE_PERF_EN.
module fpu_issue_ctl #(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 4
) (
    input logic           clk,
    input logic           rst,
    fpu_issue_ctl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ROOM_FOR_TWO = (PW + 1)'(DEPTH - 2);
    localparam logic [3:0]  OUTST_LIMIT  = 4'(MAX_OUTST);

    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   count;
    logic [12:0]   mem [DEPTH];
    logic [3:0]    outst;
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    logic          has_entry;
    logic          in_ready;
    logic          fpu_valid;
    logic          issue;
    logic          enq_first;
    logic          enq_second;
    logic [12:0]   first_op;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] wr_idx_next;
    logic [PW-1:0] rd_idx;
    logic [12:0]   head;
    logic [2:0]    resolved_rnd;
    logic          wb_take;

    function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] base, input int offset);
        return base + PW'(offset);
    endfunction

    assign count       = wr_ptr - rd_ptr;
    assign has_entry   = (count != '0);
    assign in_ready    = (count <= ROOM_FOR_TWO) && !bus.flush;
    assign fpu_valid   = has_entry && (outst < OUTST_LIMIT) && !bus.flush;
    assign issue       = fpu_valid && bus.fpu_ready;

    // A lone i1 op is still taken in order, it simply occupies the first free slot.
    assign enq_first   = in_ready && (bus.in_valid != 2'b00);
    assign enq_second  = in_ready && (bus.in_valid == 2'b11);
    assign first_op    = bus.in_valid[0] ? bus.in_op0 : bus.in_op1;
    assign wr_idx      = wr_ptr[PW-1:0];
    assign wr_idx_next = wr_idx + PW'(1);
    assign rd_idx      = rd_ptr[PW-1:0];

    assign head         = mem[rd_idx];
    assign resolved_rnd = (head[7:5] == 3'b111) ? bus.frm : head[7:5];

    // Payload reads zero while the queue is empty so the idle bus matches reset.
    assign bus.in_ready   = in_ready;
    assign bus.fpu_valid  = fpu_valid;
    assign bus.fpu_op     = has_entry ? head[12:9] : 4'd0;
    assign bus.fpu_op_mod = has_entry ? head[8]    : 1'b0;
    assign bus.fpu_rnd    = has_entry ? resolved_rnd : 3'd0;
    assign bus.fpu_rd     = has_entry ? head[4:0]  : 5'd0;
    assign bus.rnd_err    = issue && (resolved_rnd >= 3'd5);
    assign bus.rd_busy    = busy;
    assign bus.q_empty    = !has_entry && (outst == 4'd0);

    assign wb_take = bus.wb_valid && ((outst != 4'd0) || issue);

    always_ff @(posedge clk) begin
        if (enq_first) begin
            mem[wr_idx] <= first_op;
        end
        if (enq_second) begin
            mem[wr_idx_next] <= bus.in_op1;
        end
    end

    // Flush releases the scoreboard bits of every op still waiting in the queue.
    always_comb begin
        busy_next = busy;
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((PW + 1)'(i) < count) begin
                    busy_next[mem[slot_of(rd_idx, i)][4:0]] = 1'b0;
                end
            end
        end
        if (enq_first) begin
            busy_next[first_op[4:0]] = 1'b1;
        end
        if (enq_second) begin
            busy_next[bus.in_op1[4:0]] = 1'b1;
        end
        if (bus.wb_valid) begin
            busy_next[bus.wb_rd] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            outst  <= 4'd0;
            busy   <= 32'd0;
        end else begin
            wr_ptr <= wr_ptr + (PW + 1)'(enq_first) + (PW + 1)'(enq_second);
            if (bus.flush) begin
                rd_ptr <= wr_ptr;
            end else if (issue) begin
                rd_ptr <= rd_ptr + (PW + 1)'(1);
            end
            case ({issue, wb_take})
                2'b10:   outst <= outst + 4'd1;
                2'b01:   outst <= outst - 4'd1;
                default: outst <= outst;
            endcase
            busy <= busy_next;
        end
    end

    wb_without_outstanding: assert property (@(posedge clk) disable iff (rst)
        !(bus.wb_valid && (outst == 4'd0)));

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] stall_full_cnt;
    logic [31:0] stall_outst_cnt;

    // Counters saturate rather than wrap and deliberately ignore flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_full_cnt  <= 32'd0;
            stall_outst_cnt <= 32'd0;
        end else begin
            if (bus.in_valid[0] && !in_ready && (stall_full_cnt != 32'hFFFF_FFFF)) begin
                stall_full_cnt <= stall_full_cnt + 32'd1;
            end
            if (has_entry && (outst == OUTST_LIMIT) && (stall_outst_cnt != 32'hFFFF_FFFF)) begin
                stall_outst_cnt <= stall_outst_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_stall_full  = stall_full_cnt;
    assign bus.perf_stall_outst = stall_outst_cnt;
`endif
endmodule

// File: tb/tb_fpu_issue_ctl.sv
// Directed bench for fpu_issue_ctl: issued ops are checked by a scoreboard monitor,
// scoreboard bits and status flags are checked inline by the stimulus process.
module tb_fpu_issue_ctl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [3:0] op;
        logic       mod;
        logic [2:0] rnd;
        logic [4:0] rd;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    fpu_issue_ctl_if bus();

    fpu_issue_ctl #(.DEPTH(4), .MAX_OUTST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic [3:0] op, input logic mod,
                                       input logic [2:0] rnd, input logic [4:0] rd);
        return {op, mod, rnd, rd};
    endfunction

    function automatic exp_t ex(input logic [3:0] op, input logic mod, input logic [2:0] rnd,
                                input logic [4:0] rd, input logic err);
        exp_t e;
        e.op  = op;
        e.mod = mod;
        e.rnd = rnd;
        e.rd  = rd;
        e.err = err;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual %0h required %0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [12:0] op0, input logic [12:0] op1);
        bus.in_valid = valid;
        bus.in_op0   = op0;
        bus.in_op1   = op1;
        tick();
        bus.in_valid = 2'b00;
    endtask

    task automatic writeback(input logic [4:0] rd);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected issue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.fpu_valid && bus.fpu_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_issue actual rd %0d required no issue", bus.fpu_rd);
            end else begin
                e = exp_q.pop_front();
                checkOutput("issue_op",  32'(bus.fpu_op),     32'(e.op));
                checkOutput("issue_mod", 32'(bus.fpu_op_mod), 32'(e.mod));
                checkOutput("issue_rnd", 32'(bus.fpu_rnd),    32'(e.rnd));
                checkOutput("issue_rd",  32'(bus.fpu_rd),     32'(e.rd));
                checkOutput("issue_err", 32'(bus.rnd_err),    32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 2'b00;
        bus.in_op0    = 13'd0;
        bus.in_op1    = 13'd0;
        bus.flush     = 1'b0;
        bus.frm       = 3'b000;
        bus.fpu_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset_q_empty",   32'(bus.q_empty),   32'd1);
        checkOutput("reset_fpu_valid", 32'(bus.fpu_valid), 32'd0);
        checkOutput("reset_rd_busy",   bus.rd_busy,        32'd0);
        checkOutput("reset_rnd_err",   32'(bus.rnd_err),   32'd0);

        // Dual enqueue rd 3 and 7 with the FPU ready
        bus.fpu_ready = 1'b1;
        tick();
        applyStimulus(2'b11, mk(4'h3, 1'b0, 3'b000, 5'd3), mk(4'h4, 1'b1, 3'b001, 5'd7));
        exp_q.push_back(ex(4'h3, 1'b0, 3'd0, 5'd3, 1'b0));
        exp_q.push_back(ex(4'h4, 1'b1, 3'd1, 5'd7, 1'b0));
        @(negedge clk);
        checkOutput("dual_rd_busy", bus.rd_busy, 32'h88);
        tick();
        tick();
        bus.fpu_ready = 1'b0;
        writeback(5'd3);
        @(negedge clk);
        checkOutput("wb3_rd_busy", bus.rd_busy, 32'h80);
        tick();
        writeback(5'd7);
        @(negedge clk);
        checkOutput("wb7_rd_busy", bus.rd_busy, 32'h0);
        checkOutput("wb7_q_empty", 32'(bus.q_empty), 32'd1);
        tick();

        // Dynamic rounding resolution and illegal-mode pulse
        bus.frm = 3'b010;
        applyStimulus(2'b01, mk(4'h1, 1'b0, 3'b111, 5'd10), 13'd0);
        exp_q.push_back(ex(4'h1, 1'b0, 3'd2, 5'd10, 1'b0));
        bus.fpu_ready = 1'b1;
        tick();
        bus.fpu_ready = 1'b0;
        writeback(5'd10);
        bus.frm = 3'b101;
        applyStimulus(2'b11, mk(4'h2, 1'b1, 3'b111, 5'd11), mk(4'h5, 1'b0, 3'b011, 5'd12));
        exp_q.push_back(ex(4'h2, 1'b1, 3'd5, 5'd11, 1'b1));
        exp_q.push_back(ex(4'h5, 1'b0, 3'd3, 5'd12, 1'b0));
        bus.fpu_ready = 1'b1;
        tick();
        tick();
        bus.fpu_ready = 1'b0;
        @(negedge clk);
        checkOutput("rnd_err_idle", 32'(bus.rnd_err), 32'd0);
        tick();
        writeback(5'd11);
        writeback(5'd12);
        bus.frm = 3'b000;
        applyStimulus(2'b01, mk(4'h6, 1'b0, 3'b110, 5'd13), 13'd0);
        exp_q.push_back(ex(4'h6, 1'b0, 3'd6, 5'd13, 1'b1));
        bus.fpu_ready = 1'b1;
        tick();
        bus.fpu_ready = 1'b0;
        writeback(5'd13);
        @(negedge clk);
        checkOutput("rnd_q_empty", 32'(bus.q_empty), 32'd1);
        tick();

        // Backpressure until full, then drain two
        applyStimulus(2'b11, mk(4'h7, 1'b0, 3'b001, 5'd1), mk(4'h8, 1'b0, 3'b000, 5'd2));
        exp_q.push_back(ex(4'h7, 1'b0, 3'd1, 5'd1, 1'b0));
        exp_q.push_back(ex(4'h8, 1'b0, 3'd0, 5'd2, 1'b0));
        applyStimulus(2'b11, mk(4'h9, 1'b1, 3'b010, 5'd4), mk(4'hA, 1'b0, 3'b100, 5'd6));
        exp_q.push_back(ex(4'h9, 1'b1, 3'd2, 5'd4, 1'b0));
        exp_q.push_back(ex(4'hA, 1'b0, 3'd4, 5'd6, 1'b0));
        @(negedge clk);
        checkOutput("full_in_ready", 32'(bus.in_ready),  32'd0);
        checkOutput("full_head_op",  32'(bus.fpu_op),    32'h7);
        checkOutput("full_valid",    32'(bus.fpu_valid), 32'd1);
        tick();
        applyStimulus(2'b11, mk(4'hB, 1'b0, 3'b000, 5'd8), mk(4'hC, 1'b0, 3'b000, 5'd9));
        @(negedge clk);
        checkOutput("full_rd_busy", bus.rd_busy,         32'h56);
        checkOutput("stable_op",    32'(bus.fpu_op),     32'h7);
        checkOutput("stable_rd",    32'(bus.fpu_rd),     32'd1);
        tick();
        bus.fpu_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("three_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.fpu_ready = 1'b0;
        @(negedge clk);
        checkOutput("two_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // Simultaneous issue+writeback at two outstanding, then the limit
        applyStimulus(2'b11, mk(4'hB, 1'b0, 3'b000, 5'd8), mk(4'hC, 1'b1, 3'b001, 5'd9));
        exp_q.push_back(ex(4'hB, 1'b0, 3'd0, 5'd8, 1'b0));
        exp_q.push_back(ex(4'hC, 1'b1, 3'd1, 5'd9, 1'b0));
        bus.fpu_ready = 1'b1;
        writeback(5'd1);
        tick();
        tick();
        @(negedge clk);
        checkOutput("limit_valid",    32'(bus.fpu_valid), 32'd0);
        checkOutput("limit_in_ready", 32'(bus.in_ready),  32'd1);
        checkOutput("limit_q_empty",  32'(bus.q_empty),   32'd0);
        checkOutput("limit_rd_busy",  bus.rd_busy,        32'h354);
        tick();
        @(negedge clk);
        checkOutput("limit_hold", 32'(bus.fpu_valid), 32'd0);
        tick();
        writeback(5'd2);
        @(negedge clk);
        checkOutput("limit_release", 32'(bus.fpu_valid), 32'd1);
        tick();
        bus.fpu_ready = 1'b0;
        writeback(5'd4);
        writeback(5'd6);
        writeback(5'd8);
        writeback(5'd9);
        @(negedge clk);
        checkOutput("limit_drain_empty", 32'(bus.q_empty), 32'd1);
        checkOutput("limit_drain_busy",  bus.rd_busy,      32'h0);
        tick();

        // Flush with rd 2 in flight and rd 5, 9 queued
        applyStimulus(2'b01, mk(4'h1, 1'b0, 3'b000, 5'd2), 13'd0);
        exp_q.push_back(ex(4'h1, 1'b0, 3'd0, 5'd2, 1'b0));
        bus.fpu_ready = 1'b1;
        tick();
        bus.fpu_ready = 1'b0;
        applyStimulus(2'b11, mk(4'h2, 1'b0, 3'b000, 5'd5), mk(4'h3, 1'b0, 3'b000, 5'd9));
        @(negedge clk);
        checkOutput("preflush_busy", bus.rd_busy, 32'h224);
        tick();
        bus.flush     = 1'b1;
        bus.fpu_ready = 1'b1;
        bus.in_valid  = 2'b01;
        bus.in_op0    = mk(4'h4, 1'b0, 3'b000, 5'd12);
        @(negedge clk);
        checkOutput("flush_valid",    32'(bus.fpu_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(bus.in_ready),  32'd0);
        tick();
        bus.flush     = 1'b0;
        bus.in_valid  = 2'b00;
        bus.fpu_ready = 1'b0;
        @(negedge clk);
        checkOutput("postflush_busy",  bus.rd_busy,        32'h4);
        checkOutput("postflush_valid", 32'(bus.fpu_valid), 32'd0);
        checkOutput("postflush_empty", 32'(bus.q_empty),   32'd0);
        tick();
        writeback(5'd2);
        @(negedge clk);
        checkOutput("flush_wb_busy",  bus.rd_busy,      32'h0);
        checkOutput("flush_wb_empty", 32'(bus.q_empty), 32'd1);
        tick();

        // Reset with one op in flight and one queued
        applyStimulus(2'b11, mk(4'h5, 1'b1, 3'b011, 5'd20), mk(4'h6, 1'b0, 3'b000, 5'd21));
        exp_q.push_back(ex(4'h5, 1'b1, 3'd3, 5'd20, 1'b0));
        bus.fpu_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.fpu_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("rst_q_empty",   32'(bus.q_empty),   32'd1);
        checkOutput("rst_fpu_valid", 32'(bus.fpu_valid), 32'd0);
        checkOutput("rst_rd_busy",   bus.rd_busy,        32'd0);
        checkOutput("rst_fpu_op",    32'(bus.fpu_op),    32'd0);
        checkOutput("rst_fpu_rd",    32'(bus.fpu_rd),    32'd0);
        tick();

        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctl.md
Name: fpu_issue_ctl

Overview:
- Issue sequencer between decode and the shared single-port FPU datapath.
- Takes up to two FPU ops per cycle (pipe i0, pipe i1) into an in-order queue and issues one op per cycle to the FPU over a valid/ready handshake.
- Resolves dynamic rounding mode at issue.
- Keeps a 32-entry destination-register scoreboard that decode uses for RAW/WAW stalls, and supports pipeline flush.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- MAX_OUTST, 4, maximum ops issued to the FPU but not yet written back; range 1-15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all queued (not yet issued) ops
- frm  in  3  CSR dynamic rounding mode
- in_valid  in  2  bit0 = i0 op, bit1 = i1 op; bit1 only with bit0
- in_op0 / in_op1  in  13 each  {op[3:0], op_mod, rnd_mode[2:0], rd[4:0]}
- in_ready  out  1  both ops can be accepted this cycle
- fpu_valid  out  1  op presented to FPU
- fpu_ready  in  1  FPU accepts op
- fpu_op  out  4  op code
- fpu_op_mod  out  1  op modifier
- fpu_rnd  out  3  resolved rounding mode
- fpu_rd  out  5  destination register
- wb_valid  in  1  FPU writeback
- wb_rd  in  5  writeback register
- rd_busy  out  32  scoreboard; bit n set = f-reg n pending
- q_empty  out  1  queue empty and zero ops outstanding
- rnd_err  out  1  one-cycle pulse: illegal resolved rounding mode at issue

Behaviour:
- Reset: queue empty, outstanding = 0, all outputs 0 except in_ready = 1 and q_empty = 1.
- Acceptance:
  - in_ready = (free entries >= 2) && !flush.
  - An op enqueues when in_ready && in_valid[i].
  - i0 is written before i1 (program order); pointers advance by 1 or 2.
  - Write pointer wraps modulo DEPTH.
- Scoreboard set:
  - rd_busy[rd] is set the cycle after enqueue (registered).
  - Decode guarantees no enqueue to an rd that is already busy and never i0.rd == i1.rd.
  - An rd of 0 is tracked like any other register.
- Issue:
  - fpu_valid = queue not empty && outstanding < MAX_OUTST && !flush.
  - Payload comes from the head entry.
  - Head pops and outstanding increments when fpu_valid && fpu_ready; zero-cycle fall-through is not allowed (minimum one cycle from enqueue to fpu_valid).
  - Payload is stable while fpu_valid && !fpu_ready.
- Rounding:
  - rnd_mode == 3'b111 is replaced by frm at issue; otherwise passed through.
  - If the resolved value is 3'b101, 3'b110 or 3'b111, the op still issues and rnd_err pulses 1 cycle with fpu_valid && fpu_ready.
- Writeback: wb_valid clears rd_busy[wb_rd] and decrements outstanding.
- Simultaneous issue and writeback in one cycle: outstanding stays unchanged.
- wb_valid with outstanding == 0 is a protocol error (assertion); outstanding saturates at 0.
- Flush:
  - Next cycle: the queue is emptied (rd pointer = wr pointer) and rd_busy is cleared for every valid queued entry.
  - Issued ops remain outstanding and still clear their bits on writeback.
  - Enqueue and issue are blocked in the flush cycle.
  - A writeback coincident with flush is honoured.
- Full queue: in_ready = 0.
- DEPTH-1 entries: in_ready = 0 (needs 2 free).
- q_empty is combinational from registered state.
- Reset mid-operation clears everything regardless of outstanding FPU ops; the FPU is reset by the same rst.

Optional Feature:
- FPU_ISSUE_PERF_EN
- Defined: adds outputs perf_stall_full (32, count of cycles with in_valid[0] && !in_ready) and perf_stall_outst (32, count of cycles with queue non-empty && outstanding == MAX_OUTST).
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared by rst.
  - Neither is cleared by flush.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Dual enqueue: in_valid = 2'b11, rd 3 and 7, fpu_ready = 1.
  - rd_busy = 0x88 next cycle.
  - fpu_rd = 3, then 7 on consecutive cycles.
  - wb rd 3 -> rd_busy = 0x80.
- Dynamic rounding: op rnd_mode = 3'b111, frm = 3'b010 -> fpu_rnd = 2, rnd_err = 0.
  - frm = 3'b101 -> fpu_rnd = 5 and rnd_err pulses 1 cycle.
- Backpressure/full (DEPTH = 4, fpu_ready = 0):
  - Enqueue 2+2 -> in_ready = 0.
  - fpu_op holds the head value stable.
  - After 2 handshakes in_ready = 1.
- Outstanding limit (MAX_OUTST = 4):
  - After 4 issues with no writeback, fpu_valid = 0 with queue non-empty.
  - One wb_valid -> fpu_valid = 1 the next cycle.
- Flush with 2 queued (rd 5, 9) and 1 in flight (rd 2):
  - Next cycle rd_busy = 0x4 and the queue is empty.
  - wb rd 2 -> rd_busy = 0, q_empty = 1.
- Simultaneous issue + writeback at outstanding = 2 -> remains 2.
- Reset asserted mid-stream -> all outputs return to reset values next cycle.
